// File: rtl/eeprom_arbiter_if.sv
// Bundle of requester-side and engine-side signals for the EEPROM arbiter.
// The slave modport is the arbiter's view. The master modport is the
// environment's view (requesters plus engine).
interface eeprom_arbiter_if;
  logic        r0_req,   r1_req;
  logic        r0_we,    r1_we;
  logic [10:0] r0_addr,  r1_addr;
  logic [7:0]  r0_wdata, r1_wdata;
  logic        r0_gnt,   r1_gnt;
  logic        r0_done,  r1_done;
  logic        r0_err,   r1_err;
  logic [7:0]  r0_rdata, r1_rdata;
  logic        eng_wr, eng_rd;
  logic [10:0] eng_addr;
  logic [7:0]  eng_wdata;
  logic [7:0]  eng_rdata;
  logic        eng_ack;

  modport slave (
    input  r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata,
           eng_rdata, eng_ack,
    output r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err, r0_rdata, r1_rdata,
           eng_wr, eng_rd, eng_addr, eng_wdata
  );

  modport master (
    output r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata,
           eng_rdata, eng_ack,
    input  r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err, r0_rdata, r1_rdata,
           eng_wr, eng_rd, eng_addr, eng_wdata
  );
endinterface

// File: rtl/eeprom_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the serial EEPROM engine.
// All outputs are registers. Requests are sampled only in IDLE. A transfer
// ends on the engine ack, or on timeout after TIMEOUT cycles in WAIT.
module eeprom_arbiter #(
  parameter int TIMEOUT = 4096,
  parameter int TW      = 16
) (
  input logic            CLK,
  input logic            RESET,
  eeprom_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  state_t          state;
  logic            sel, last, we_q;
  logic [TW-1:0]   cnt;
  logic [1:0]      gnt, done, err;
  logic [1:0][7:0] rdata;
  logic [10:0]     addr_q;
  logic [7:0]      wdata_q;
  logic            wr_q, rd_q;
  logic [1:0]      req;
  logic            win;

  assign req = {bus.r1_req, bus.r0_req};

  // Winner: the only requester, or on a tie the port that did not win last time.
  always_comb begin
    win = req[1];
    if (req == 2'b11) win = ~last;
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      sel     <= 1'b0;
      last    <= 1'b1;
      we_q    <= 1'b0;
      cnt     <= '0;
      gnt     <= '0;
      done    <= '0;
      err     <= '0;
      rdata   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            sel     <= win;
            last    <= win;
            we_q    <= win ? bus.r1_we    : bus.r0_we;
            addr_q  <= win ? bus.r1_addr  : bus.r0_addr;
            wdata_q <= win ? bus.r1_wdata : bus.r0_wdata;
            wr_q    <= win ? bus.r1_we    : bus.r0_we;
            rd_q    <= win ? ~bus.r1_we   : ~bus.r0_we;
            gnt     <= win ? 2'b10 : 2'b01;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          wr_q  <= 1'b0;
          rd_q  <= 1'b0;
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // Ack beats expiry when both land in the same cycle.
          if (bus.eng_ack) begin
            if (!we_q) rdata[sel] <= bus.eng_rdata;
            done[sel] <= 1'b1;
            state     <= DONE;
          end else if (cnt == CNT_LAST) begin
            done[sel] <= 1'b1;
            err[sel]  <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          gnt   <= '0;
          done  <= '0;
          err   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.r0_gnt    = gnt[0];
  assign bus.r1_gnt    = gnt[1];
  assign bus.r0_done   = done[0];
  assign bus.r1_done   = done[1];
  assign bus.r0_err    = err[0];
  assign bus.r1_err    = err[1];
  assign bus.r0_rdata  = rdata[0];
  assign bus.r1_rdata  = rdata[1];
  assign bus.eng_wr    = wr_q;
  assign bus.eng_rd    = rd_q;
  assign bus.eng_addr  = addr_q;
  assign bus.eng_wdata = wdata_q;
endmodule

// File: tb/tb_eeprom_arbiter.sv
// Randomized bench for eeprom_arbiter. The reference model works at the
// transaction level. On each grant it computes the ISSUE and DONE cycles and
// the error outcome from the timing rules. Each cycle it checks every output
// against those cycle numbers.
module tb_eeprom_arbiter;
  localparam int TO   = 8;
  localparam int NCYC = 4000;

  logic CLK = 1'b0;
  logic RESET;
  eeprom_arbiter_if bus();

  eeprom_arbiter #(.TIMEOUT(TO), .TW(4)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  // requester-side stimulus state
  logic [1:0]       req, we;
  logic [1:0][10:0] addr;
  logic [1:0][7:0]  wdata;
  logic             ack;
  logic [7:0]       erd;

  // transaction-level model
  logic [1:0][7:0] m_rdata;
  logic            m_last;
  logic [10:0]     m_addr;
  logic [7:0]      m_wdata;
  bit              act, t_we, t_err;
  int              own, issue_c, done_c, ack_c, nrst;
  logic [7:0]      rd_byte;

  task automatic model_reset();
    m_rdata = '0; m_last = 1'b1; m_addr = '0; m_wdata = '0;
    act = 0; own = 0; issue_c = -10; done_c = -10; ack_c = -1;
  endtask

  task automatic new_req(input int p);
    req[p] = 1'b1; we[p] = 1'($urandom); addr[p] = 11'($urandom); wdata[p] = 8'($urandom);
  endtask

  // Compare every output against what the model says cycle c must show.
  task automatic check_outputs(input int c);
    logic [1:0] eg, ed, ee;
    logic ewr, erdx;
    eg = '0; ed = '0; ee = '0; ewr = 1'b0; erdx = 1'b0;
    if (act && c >= issue_c && c <= done_c) eg[own] = 1'b1;
    if (act && c == issue_c) begin ewr = t_we; erdx = !t_we; end
    if (act && c == done_c) begin
      ed[own] = 1'b1;
      ee[own] = t_err;
      if (!t_err && !t_we) m_rdata[own] = rd_byte;
    end
    chk("gnt",      32'({bus.r1_gnt, bus.r0_gnt}),   32'(eg));
    chk("done",     32'({bus.r1_done, bus.r0_done}), 32'(ed));
    chk("err",      32'({bus.r1_err, bus.r0_err}),   32'(ee));
    chk("r0_rdata", 32'(bus.r0_rdata), 32'(m_rdata[0]));
    chk("r1_rdata", 32'(bus.r1_rdata), 32'(m_rdata[1]));
    chk("eng_wr",   32'(bus.eng_wr),   32'(ewr));
    chk("eng_rd",   32'(bus.eng_rd),   32'(erdx));
    chk("eng_addr", 32'(bus.eng_addr), 32'(m_addr));
    chk("eng_wdata",32'(bus.eng_wdata),32'(m_wdata));
  endtask

  // Choose the inputs for cycle c and advance the model by the decision
  // the arbiter makes at the end of that cycle.
  task automatic drive(input int c);
    bit idle, in_wait;
    int win, d, r;
    RESET   = 1'b0;
    idle    = !act || c > done_c;
    in_wait = act && c > issue_c && c < done_c;

    for (int p = 0; p < 2; p++) begin
      if (act && c == done_c && own == p) begin
        if ($urandom_range(1, 0) == 0) req[p] = 1'b0; else new_req(p);
      end else if (!req[p]) begin
        if ($urandom_range(2, 0) == 0) new_req(p);
      end else if (!idle && own == p && $urandom_range(24, 0) == 0) begin
        req[p] = 1'b0;
      end
    end

    erd = 8'($urandom);
    ack = 1'b0;
    if (in_wait && c == ack_c) begin
      ack = 1'b1; rd_byte = erd;
    end else if (!in_wait && $urandom_range(5, 0) == 0) begin
      ack = 1'b1;
    end

    if (c < 2 || (in_wait && c > 50 && nrst < 4 && $urandom_range(39, 0) == 0)) begin
      RESET = 1'b1;
      if (c >= 2) nrst++;
      model_reset();
    end else if (idle && (req != 2'b00)) begin
      if (req == 2'b11) win = (m_last == 1'b1) ? 0 : 1;
      else win = req[1] ? 1 : 0;
      own = win; m_last = 1'(win); act = 1;
      issue_c = c + 1;
      t_we = we[win]; m_addr = addr[win]; m_wdata = wdata[win];
      r = int'($urandom_range(9, 0));
      if (r < 6) d = int'($urandom_range(5, 1));
      else if (r < 8) d = TO;
      else d = 0;
      if (d > 0) begin
        ack_c = issue_c + d; done_c = ack_c + 1; t_err = 0;
      end else begin
        ack_c = -1; done_c = issue_c + 1 + TO; t_err = 1;
      end
    end

    bus.r0_req = req[0];  bus.r1_req = req[1];
    bus.r0_we = we[0];    bus.r1_we = we[1];
    bus.r0_addr = addr[0];   bus.r1_addr = addr[1];
    bus.r0_wdata = wdata[0]; bus.r1_wdata = wdata[1];
    bus.eng_ack = ack;    bus.eng_rdata = erd;
  endtask

  initial begin
    RESET = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0; ack = 1'b0; erd = '0;
    rd_byte = '0; t_we = 0; t_err = 0; nrst = 0;
    model_reset();
    bus.r0_req = 1'b0; bus.r1_req = 1'b0; bus.r0_we = 1'b0; bus.r1_we = 1'b0;
    bus.r0_addr = '0; bus.r1_addr = '0; bus.r0_wdata = '0; bus.r1_wdata = '0;
    bus.eng_ack = 1'b0; bus.eng_rdata = '0;
    @(negedge CLK);
    for (int c = 0; c < NCYC; c++) begin
      cyc = c;
      check_outputs(c);
      drive(c);
      @(negedge CLK);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/eeprom_arbiter.md
# eeprom_arbiter

Two-port arbiter and sequencer for the serial EEPROM read/write engine. It accepts byte-read and byte-write requests from two independent requesters and grants the engine to one of them at a time, using round-robin priority. It issues the engine's WR/RD strobe and waits for the engine's completion ACK, with a timeout. It then returns read data and a done/error pulse to the granted requester. It sits between the system-side masters (e.g. boot loader on port 0, host register port on port 1) and the engine.

## Interface
Parameters:
- TIMEOUT, 4096: maximum CLK cycles spent in WAIT before the transfer is abandoned; legal range 2..65535.
- TW, 16: width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports (clock and reset: clock CLK; reset RESET, synchronous, active-high):
- CLK  in  1  system clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- r0_req / r1_req  in  1  request level; held high until the matching done.
- r0_we / r1_we  in  1  1 = byte write, 0 = byte read; stable while req is high.
- r0_addr / r1_addr  in  11  EEPROM byte address; stable while req is high.
- r0_wdata / r1_wdata  in  8  write data; stable while req is high.
- r0_gnt / r1_gnt  out  1  high from ISSUE through DONE for the granted port.
- r0_done / r1_done  out  1  one-cycle completion pulse.
- r0_err / r1_err  out  1  one-cycle pulse, coincident with done, on timeout.
- r0_rdata / r1_rdata  out  8  last read byte for that port; held until the next successful read on that port.
- eng_wr / eng_rd  out  1  one-cycle start strobe to the engine.
- eng_addr  out  11  registered address; stable from ISSUE until back in IDLE.
- eng_wdata  out  8  registered write data; stable from ISSUE until back in IDLE.
- eng_rdata  in  8  engine read byte; valid in the cycle eng_ack is high.
- eng_ack  in  1  engine completion pulse, one cycle.

## Operation
- Registered FSM with four states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - No request: stay in IDLE.
  - Exactly one req high: that port wins.
  - Both high: the port not equal to `last` wins.
  - On a win: latch sel, addr, wdata and we into eng_addr/eng_wdata/we_q, set `last` <= sel, go to ISSUE.
- **ISSUE** (one cycle)
  - gnt[sel] = 1.
  - eng_wr = we_q and eng_rd = !we_q.
  - Clear the timeout counter; go to WAIT.
- **WAIT**
  - gnt[sel] = 1; counter increments each cycle.
  - eng_ack = 1: if !we_q, load rdata[sel] <= eng_rdata; go to DONE with err_q = 0.
  - Otherwise, counter == TIMEOUT-1: go to DONE with err_q = 1; rdata is unchanged.
  - eng_ack seen in the same cycle as expiry: ack wins, no error.
- **DONE** (one cycle)
  - gnt[sel] = 1, done[sel] = 1, err[sel] = err_q.
  - Go to IDLE.
- eng_ack outside WAIT is ignored; no state change and no rdata update.
- req is sampled only in IDLE. A req still high in the cycle after done is treated as a new request.
- A req that drops before done does not abort the transfer; the transfer completes and done still pulses.
- Requester identity is not exposed to the engine; the engine sees a single master.

## Timing
- Reset values:
  - State IDLE; `last` = 1, so port 0 wins the first tie.
  - All gnt, done, err, eng_wr and eng_rd = 0.
  - eng_addr = 0, eng_wdata = 0, r0_rdata = r1_rdata = 0, counter = 0.
- Outputs are decoded from registered state only; there are no combinational paths from inputs to outputs.
- Cycle sequence, with req first seen high in IDLE at cycle t:
  - t+1: ISSUE; gnt and strobe high.
  - t+2 onward: WAIT.
  - eng_ack at cycle a: DONE at a+1 (done, rdata visible); IDLE at a+2.
  - Earliest next grant: ISSUE at a+3.
- Minimum turnaround is 4 cycles per transfer, with eng_ack at t+2.
- Timeout: with no ack, DONE occurs at t+2+TIMEOUT and err pulses there.
- RESET high mid-transfer: next cycle is IDLE with all outputs at reset values. No done is issued for the aborted request; the engine must be reset on the same RESET.
- gnt drops in the cycle after DONE.

## Test plan
- Single write, port 0: r0_req=1, we=1, addr=11'h155, wdata=8'hA5 at t; eng_ack at t+5 → eng_wr pulse at t+1, eng_addr=155h, eng_wdata=A5h, r0_done at t+6, r0_err=0, r1 outputs all 0.
- Single read, port 1: addr=11'h7FF, eng_rdata=8'h3C with eng_ack at t+10 → eng_rd pulse at t+1, r1_rdata=3Ch from t+11 onward, r1_done at t+11, r0_rdata unchanged.
- Tie and fairness: both req high from reset, held, each ack 3 cycles after ISSUE → grant order 0,1,0,1; no port granted twice while the other waits.
- Timeout: TIMEOUT=8, port 0 read, no eng_ack → r0_done and r0_err together at t+10, r0_rdata unchanged; a late ack at t+12 is ignored.
- Stray ack and ack/expiry collision: eng_ack pulsed in IDLE → no response. Ack in the expiry cycle → err=0 and rdata updated.
- Reset mid-WAIT: RESET for one cycle during WAIT → all outputs 0 the next cycle, no done. A pending r1_req is then granted normally.
